// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl -- CP0 register file, exception/interrupt sequencer and pipeline
// flush/write-enable controller for a five-stage MIPS-style pipeline.
//
// Exceptions are evaluated for the instruction sitting in MEM. A taken
// interrupt, SYSCALL or ERET redirects the PC in the same cycle and flushes the
// younger stages. The FSM then spends one SETTLE cycle during which nothing can
// be taken, so the redirected fetch gets into the pipe first.
//
// Parameters
//   NUM_IRQ    : number of hardware interrupt lines (1..6), IrqIn[k] -> IP[2+k]
//   BOOT_EBASE : reset value of EBASE
//
// Configuration macro
//   VECTORED_INT_EN : when defined, interrupts vector to EBASE+0x200+0x20*n,
//                     where n is the highest pending unmasked IP bit.
//                     SYSCALL always uses EBASE+0x180. When undefined, every
//                     exception uses EBASE+0x180.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   CurrentPC          : PC of the MEM-stage instruction
//   ExcDelay           : MEM-stage instruction sits in a branch delay slot
//   ExcSyscall/ExcEret : MEM-stage instruction is SYSCALL / ERET
//   IrqIn              : level-sensitive hardware interrupts
//   HazardStall        : load-use stall request
//   MemBusy            : memory stage not ready
//   CP0WE/WAddr/WData  : MTC0 write port
//   CP0RAddr/CP0RData  : MFC0 combinational read port
//   ExcRedirect/ExcPC  : PC redirect request and target
//   *Flush / *WE       : per-stage clear and write enable
// -----------------------------------------------------------------------------
module exc_ctrl #(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] BOOT_EBASE = 32'h8000_1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        CurrentPC,
  input  logic               ExcDelay,
  input  logic               ExcSyscall,
  input  logic               ExcEret,
  input  logic [NUM_IRQ-1:0] IrqIn,
  input  logic               HazardStall,
  input  logic               MemBusy,
  input  logic               CP0WE,
  input  logic [4:0]         CP0WAddr,
  input  logic [31:0]        CP0WData,
  input  logic [4:0]         CP0RAddr,
  output logic [31:0]        CP0RData,
  output logic               ExcRedirect,
  output logic [31:0]        ExcPC,
  output logic               PCFlush,
  output logic               IFIDFlush,
  output logic               IDEXFlush,
  output logic               EXMEFlush,
  output logic               MEWBFlush,
  output logic               PCWE,
  output logic               IFIDWE,
  output logic               IDEXWE,
  output logic               EXMEWE,
  output logic               MEWBWE
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_EBASE   = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  typedef enum logic {RUN, SETTLE} state_e;

  state_e state_q, state_d;

  logic [7:0]         statusIm_q;
  logic               statusExl_q;
  logic               statusIe_q;
  logic               causeBd_q;
  logic               causeTi_q;
  logic [1:0]         causeSwIp_q;
  logic [NUM_IRQ-1:0] causeHwIp_q;
  logic [4:0]         causeExcCode_q;
  logic [31:0]        epc_q;
  logic [31:0]        count_q;
  logic [31:0]        compare_q;
  logic [17:0]        ebaseField_q;

  logic [31:0] ebase;
  logic [7:0]  causeIp;
  logic [7:0]  pendingMask;
  logic        intPending;
  logic        evalEn;
  logic        takeInt;
  logic        takeSys;
  logic        takeEret;
  logic        takeAny;
  logic        cp0Write;
  logic [31:0] intTarget;
  logic [31:0] sysTarget;

  // Only bits 29:12 of EBASE are software visible; the rest are fixed at boot.
  assign ebase = {BOOT_EBASE[31:30], ebaseField_q, BOOT_EBASE[11:0]};

  // Assemble the 8-bit IP view. IP[7] doubles as the timer line; with six
  // hardware lines IrqIn[5] shares it, so the two are ORed.
  always_comb begin
    causeIp      = 8'b0;
    causeIp[1:0] = causeSwIp_q;
    for (int k = 0; k < NUM_IRQ; k++) begin
      causeIp[2+k] = causeHwIp_q[k];
    end
    causeIp[7] = causeIp[7] | causeTi_q;
  end

  assign pendingMask = causeIp & statusIm_q;
  assign intPending  = statusIe_q & ~statusExl_q & (|pendingMask);

  // Priority: interrupt > syscall > eret, only in RUN with memory ready.
  assign evalEn   = (state_q == RUN) & ~MemBusy;
  assign takeInt  = evalEn & intPending;
  assign takeSys  = evalEn & ~intPending & ExcSyscall;
  assign takeEret = evalEn & ~intPending & ~ExcSyscall & ExcEret;
  assign takeAny  = takeInt | takeSys | takeEret;

  // An MTC0 in the same cycle as a take belongs to a flushed context.
  assign cp0Write = CP0WE & ~takeAny;

  assign sysTarget = ebase + 32'h0000_0180;

`ifdef VECTORED_INT_EN
  logic [2:0] vecIdx;

  // Highest-numbered pending unmasked IP selects the vector slot.
  always_comb begin
    vecIdx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pendingMask[i]) vecIdx = 3'(i);
    end
  end

  assign intTarget = ebase + 32'h0000_0200 + {24'b0, vecIdx, 5'b0};
`else
  assign intTarget = sysTarget;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: a take always buys exactly one SETTLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (takeAny) state_d = SETTLE;
      SETTLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: reset overrides everything, then take, then normal flow.
  always_comb begin
    ExcRedirect = 1'b0;
    ExcPC       = 32'b0;
    PCFlush     = 1'b0;
    IFIDFlush   = 1'b0;
    IDEXFlush   = HazardStall & ~MemBusy;
    EXMEFlush   = 1'b0;
    MEWBFlush   = MemBusy;
    PCWE        = ~HazardStall & ~MemBusy;
    IFIDWE      = ~HazardStall & ~MemBusy;
    IDEXWE      = ~MemBusy;
    EXMEWE      = ~MemBusy;
    MEWBWE      = 1'b1;
    if (rst) begin
      PCFlush   = 1'b1;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      EXMEFlush = 1'b1;
      MEWBFlush = 1'b1;
      PCWE      = 1'b0;
      IFIDWE    = 1'b0;
      IDEXWE    = 1'b0;
      EXMEWE    = 1'b0;
      MEWBWE    = 1'b0;
    end else if (takeAny) begin
      ExcRedirect = 1'b1;
      if (takeInt)      ExcPC = intTarget;
      else if (takeSys) ExcPC = sysTarget;
      else              ExcPC = epc_q;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      EXMEFlush = 1'b1;
      MEWBFlush = 1'b1;
      PCWE      = 1'b1;
      IFIDWE    = 1'b1;
      IDEXWE    = 1'b1;
      EXMEWE    = 1'b1;
      MEWBWE    = 1'b1;
    end
  end

  // Free-running timer. TI is sticky until software rewrites COMPARE, and the
  // clear wins over a coincident match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 32'b0;
      compare_q <= 32'hFFFF_FFFF;
      causeTi_q <= 1'b0;
    end else begin
      if (cp0Write && CP0WAddr == ADDR_COUNT) count_q <= CP0WData;
      else                                    count_q <= count_q + 32'd1;
      if (cp0Write && CP0WAddr == ADDR_COMPARE) begin
        compare_q <= CP0WData;
        causeTi_q <= 1'b0;
      end else if (count_q == compare_q) begin
        causeTi_q <= 1'b1;
      end
    end
  end

  // STATUS, CAUSE, EPC and EBASE. Exception entry/return takes priority over
  // software writes (which are dropped on a take anyway).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statusIm_q     <= 8'b0;
      statusExl_q    <= 1'b0;
      statusIe_q     <= 1'b0;
      causeBd_q      <= 1'b0;
      causeSwIp_q    <= 2'b0;
      causeHwIp_q    <= '0;
      causeExcCode_q <= 5'b0;
      epc_q          <= 32'b0;
      ebaseField_q   <= BOOT_EBASE[29:12];
    end else begin
      causeHwIp_q <= IrqIn;
      if (takeInt || takeSys) begin
        statusExl_q    <= 1'b1;
        causeBd_q      <= ExcDelay;
        causeExcCode_q <= takeInt ? EXC_INT : EXC_SYS;
        epc_q          <= ExcDelay ? (CurrentPC - 32'd4) : CurrentPC;
      end else if (takeEret) begin
        statusExl_q <= 1'b0;
      end else if (cp0Write) begin
        case (CP0WAddr)
          ADDR_STATUS: begin
            statusIm_q  <= CP0WData[15:8];
            statusExl_q <= CP0WData[1];
            statusIe_q  <= CP0WData[0];
          end
          ADDR_CAUSE: causeSwIp_q  <= CP0WData[9:8];
          ADDR_EPC:   epc_q        <= CP0WData;
          ADDR_EBASE: ebaseField_q <= CP0WData[29:12];
          default: ;
        endcase
      end
    end
  end

  // MFC0 read mux; unimplemented registers read as zero.
  always_comb begin
    CP0RData = 32'b0;
    case (CP0RAddr)
      ADDR_COUNT:   CP0RData = count_q;
      ADDR_COMPARE: CP0RData = compare_q;
      ADDR_STATUS:  CP0RData = {16'b0, statusIm_q, 6'b0, statusExl_q, statusIe_q};
      ADDR_CAUSE:   CP0RData = {causeBd_q, causeTi_q, 14'b0, causeIp, 1'b0,
                                causeExcCode_q, 2'b0};
      ADDR_EPC:     CP0RData = epc_q;
      ADDR_EBASE:   CP0RData = ebase;
      default:      CP0RData = 32'b0;
    endcase
  end

endmodule
